// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  typedef enum logic {
    FETCH,
    FLUSH
  } fetch_state_t;

  // Instructions are word aligned; low address bits are discarded.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with clear; DEPTH must be a power of two.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  fetch_entry_t             data_in,
  input  logic                     pop,
  input  logic                     clear,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible once counted.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= data_in;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, in-order imem reads, response buffer, redirect flush.
// Optional FETCH_BYPASS_EN forwards a response straight to the decoder when the buffer is empty.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned SUM_W = CNT_W + 1;

  fetch_state_t   state;
  logic [31:0]    pc;
  logic [31:0]    resp_pc;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] outstanding_next;
  logic [CNT_W-1:0] drop;

  fetch_entry_t   fifo_head;
  fetch_entry_t   resp_entry;
  fetch_entry_t   out_entry;
  logic [CNT_W-1:0] fifo_count;
  logic           fifo_full;
  logic           fifo_empty;
  logic           fifo_push;
  logic           fifo_pop;

  logic           credit_ok;
  logic           req_fire;
  logic           resp_keep;
  logic           pop_fire;
  logic [31:0]    redirect_target;

  assign redirect_target = align_word(redirect_pc);
  assign credit_ok = (SUM_W'(fifo_count) + SUM_W'(outstanding)) < SUM_W'(FIFO_DEPTH);

  // Requests are suppressed while flushing and in the redirect cycle itself.
  assign imem_req_valid = !reset && (state == FETCH) && credit_ok && !redirect_valid;
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign resp_keep  = imem_resp_valid && (drop == '0) && !redirect_valid;
  assign resp_entry = '{pc: resp_pc, instr: imem_resp_data};
  assign outstanding_next = outstanding + CNT_W'(req_fire) - CNT_W'(imem_resp_valid);

`ifdef FETCH_BYPASS_EN
  logic bypass;

  always_comb begin
    bypass      = fifo_empty && resp_keep;
    instr_valid = !fifo_empty || bypass;
    out_entry   = '{pc: '0, instr: NOP_INSTR};
    if (!fifo_empty)  out_entry = fifo_head;
    else if (bypass)  out_entry = resp_entry;
    pop_fire  = instr_valid && instr_ready && !redirect_valid;
    fifo_pop  = pop_fire && !fifo_empty;
    fifo_push = resp_keep && !(bypass && pop_fire) && (!fifo_full || fifo_pop);
  end
`else
  always_comb begin
    instr_valid = !fifo_empty;
    out_entry   = '{pc: '0, instr: NOP_INSTR};
    if (!fifo_empty) out_entry = fifo_head;
    pop_fire  = instr_valid && instr_ready && !redirect_valid;
    fifo_pop  = pop_fire;
    fifo_push = resp_keep && (!fifo_full || fifo_pop);
  end
`endif

  assign instr    = out_entry.instr;
  assign instr_pc = out_entry.pc;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (fifo_push),
    .data_in (resp_entry),
    .pop     (fifo_pop),
    .clear   (redirect_valid),
    .head    (fifo_head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Fetch FSM with PC, response-PC, credit and drop tracking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      outstanding <= outstanding_next;
      if (redirect_valid) begin
        // Everything still in flight after this cycle belongs to the old path.
        pc      <= redirect_target;
        resp_pc <= redirect_target;
        drop    <= outstanding_next;
        state   <= (outstanding_next != '0) ? FLUSH : FETCH;
      end else begin
        if (req_fire) pc <= pc + 32'd4;
        if (imem_resp_valid) begin
          if (drop != '0) drop    <= drop - CNT_W'(1);
          else            resp_pc <= resp_pc + 32'd4;
        end
        case (state)
          FETCH: state <= FETCH;
          FLUSH: begin
            if ((drop == '0) || ((drop == CNT_W'(1)) && imem_resp_valid)) state <= FETCH;
          end
          default: state <= FETCH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: in-order memory model plus a sequential-PC reference for the decoder stream.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam int          DEPTH    = 4;
`ifdef FETCH_BYPASS_EN
  localparam int          EXP_FIRST = 1;
`else
  localparam int          EXP_FIRST = 2;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b0;

  fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .instr_valid     (instr_valid),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .instr_ready     (instr_ready)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Instruction memory contents as a function of address.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction

  // Memory model and reference state.
  logic [31:0] addr_q[$];
  int          due_q[$];
  int          cyc, lat, last_due;
  logic [31:0] exp_pc, exp_req, held_addr, first_xfer_pc;
  int          n_acc, n_xfer, n_resp, first_xfer_cyc;
  logic        hold_pending, resp_now;

  task automatic clear_model();
    addr_q.delete();
    due_q.delete();
    cyc = 0; last_due = 0;
    exp_pc = RESET_PC; exp_req = RESET_PC;
    n_acc = 0; n_xfer = 0; n_resp = 0;
    first_xfer_cyc = -1; first_xfer_pc = '0;
    hold_pending = 1'b0;
  endtask

  // Called just after a rising edge; asserts reset asynchronously.
  task automatic apply_reset();
    reset = 1'b1;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0;
    redirect_valid = 1'b0; instr_ready = 1'b0;
    #1;
    check_eq("rst_req_valid", imem_req_valid, 1'b0);
    check_eq("rst_req_addr", imem_req_addr, RESET_PC);
    check_eq("rst_instr_valid", instr_valid, 1'b0);
    check_eq("rst_instr", instr, NOP);
    check_eq("rst_instr_pc", instr_pc, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    clear_model();
  endtask

  // One cycle: drive inputs, sample settled outputs, update reference, advance.
  task automatic step(input logic rq_rdy, input logic in_rdy, input logic redir, input logic [31:0] rpc);
    logic accept, xfer;
    imem_req_ready = rq_rdy;
    instr_ready    = in_rdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    resp_now = (addr_q.size() > 0) && (due_q[0] <= cyc);
    imem_resp_valid = resp_now;
    if (resp_now) begin
      imem_resp_data = memf(addr_q[0]);
      void'(addr_q.pop_front());
      void'(due_q.pop_front());
      n_resp++;
    end else begin
      imem_resp_data = $urandom;
    end
    #1;
    if (redir) check_eq("req_gated_on_redirect", imem_req_valid, 1'b0);
    else if (hold_pending) check_eq("req_hold", {imem_req_valid, imem_req_addr}, {1'b1, held_addr});
    accept = imem_req_valid && imem_req_ready;
    if (accept) begin
      int due;
      check_eq("req_addr", imem_req_addr, exp_req);
      due = cyc + lat;
      if (due < last_due) due = last_due;
      last_due = due;
      addr_q.push_back(imem_req_addr);
      due_q.push_back(due);
      check_eq("credit", addr_q.size() <= DEPTH, 1'b1);
      exp_req = exp_req + 32'd4;
      n_acc++;
    end
    hold_pending = imem_req_valid && !imem_req_ready;
    held_addr    = imem_req_addr;
    xfer = instr_valid && instr_ready && !redir;
    if (xfer) begin
      check_eq("instr_pc", instr_pc, exp_pc);
      check_eq("instr", instr, memf(exp_pc));
      if (n_xfer == 0) begin
        first_xfer_cyc = cyc;
        first_xfer_pc  = instr_pc;
      end
      exp_pc = exp_pc + 32'd4;
      n_xfer++;
    end
    if (redir) begin
      exp_pc  = {rpc[31:2], 2'b00};
      exp_req = {rpc[31:2], 2'b00};
      hold_pending = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    int mark, acc_mark, resp_mark, drop_seen;
    logic did_mid_reset;
    clear_model();
    lat = 1;
    @(posedge clk);
    #1;

    // Reset values and streaming latency with single-cycle memory.
    apply_reset();
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0, '0);
    check_eq("first_valid_cycle", first_xfer_cyc, EXP_FIRST);
    check_eq("first_pc", first_xfer_pc, RESET_PC);
    check_eq("sustained_rate", n_xfer, 12 - EXP_FIRST);

    // Decoder stalled: buffer plus credits cap requests at DEPTH.
    apply_reset();
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b0, '0);
    check_eq("stall_acc", n_acc, DEPTH);
    check_eq("stall_req_valid", imem_req_valid, 1'b0);
    check_eq("stall_instr_valid", instr_valid, 1'b1);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b0, '0);
    check_eq("held_entries", n_xfer, DEPTH);
    check_eq("drained_valid", instr_valid, 1'b0);

    // Memory not ready for three cycles.
    apply_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, '0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, '0);
    check_eq("stall_addr", imem_req_addr, exp_req);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, '0);

    // Redirect with three requests in flight at five-cycle latency.
    apply_reset();
    lat = 5;
    for (int i = 0; i < 20 && n_acc < 3; i++) step(1'b1, 1'b0, 1'b0, '0);
    check_eq("inflight3", addr_q.size(), 3);
    acc_mark = n_acc;
    resp_mark = n_resp;
    drop_seen = -1;
    step(1'b1, 1'b0, 1'b1, 32'h0000_0103);
    for (int i = 0; i < 40 && n_xfer == 0; i++) begin
      step(1'b1, 1'b1, 1'b0, '0);
      if (drop_seen < 0 && n_acc != acc_mark) drop_seen = n_resp - resp_mark;
    end
    check_eq("dropped_before_refetch", drop_seen, 3);
    check_eq("redirect_first_pc", first_xfer_pc, 32'h0000_0100);

    // Redirect coinciding with a pop and a response.
    apply_reset();
    lat = 2;
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, '0);
    check_eq("setup_valid", instr_valid, 1'b1);
    mark = n_xfer;
    step(1'b1, 1'b1, 1'b1, 32'h0000_0040);
    check_eq("setup_resp", resp_now, 1'b1);
    redirect_valid = 1'b0;
    imem_resp_valid = 1'b0;
    #1;
    check_eq("flush_empty", instr_valid, 1'b0);
    for (int i = 0; i < 14; i++) step(1'b1, 1'b1, 1'b0, '0);
    check_eq("post_redirect_progress", n_xfer > mark, 1'b1);

    // Randomized traffic with redirects and one mid-stream reset.
    apply_reset();
    did_mid_reset = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      lat = $urandom_range(1, 6);
      if (!did_mid_reset && i >= 1500 && addr_q.size() > 0) begin
        did_mid_reset = 1'b1;
        apply_reset();
      end
      step(($urandom % 10) < 7, ($urandom % 10) < 6, ($urandom % 40) == 0, $urandom);
    end
    check_eq("mid_reset_done", did_mid_reset, 1'b1);

    // Liveness once traffic settles.
    mark = n_xfer;
    for (int i = 0; i < 200 && n_xfer < mark + 20; i++) step(1'b1, 1'b1, 1'b0, '0);
    check_eq("drain_progress", n_xfer >= mark + 20, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
